// File: rtl/mouse_master_fsm_if.sv
// PS/2 mouse sequencer bus: transmitter/receiver handshakes and packet outputs.
interface mouse_master_fsm_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic       INIT_DONE;
  logic [7:0] PKT_ERR_CNT;

  modport master (
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    output MOUSE_STATUS, MOUSE_DX, MOUSE_DY,
    output SEND_INTERRUPT, INIT_DONE, PKT_ERR_CNT,
    input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE,
    input  BYTE_READY
  );

  modport slave (
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    input  MOUSE_STATUS, MOUSE_DX, MOUSE_DY,
    input  SEND_INTERRUPT, INIT_DONE, PKT_ERR_CNT,
    output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE,
    output BYTE_READY
  );
endinterface

// File: rtl/mouse_master_fsm.sv
// PS/2 mouse top sequencer: reset/enable handshake, then
// 3-byte stream packet assembly with interrupt per packet.
module mouse_master_fsm #(
  parameter int unsigned T_INIT = 5_000_000,
  parameter int unsigned T_RESP = 5_000_000,
  parameter int unsigned T_PKT  = 100_000,
  parameter int unsigned CTR_W  = 24
) (
  input  logic                CLK,
  input  logic                RESET_N,
  mouse_master_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_SEND_FF, S_WAIT_FF,
    S_ACK_FF, S_SELFTEST, S_ID,
    S_SEND_F4, S_WAIT_F4, S_ACK_F4,
    S_B0, S_B1, S_B2, S_PUBLISH
  } state_e;

  localparam logic [CTR_W-1:0] LIM_INIT =
    CTR_W'(T_INIT - 1);
  localparam logic [CTR_W-1:0] LIM_RESP =
    CTR_W'(T_RESP - 1);
  localparam logic [CTR_W-1:0] LIM_PKT =
    CTR_W'(T_PKT - 1);

  state_e           state_q, state_d;
  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic [CTR_W-1:0] lim;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       b0_q, b0_d;
  logic [7:0]       b1_q, b1_d;
  logic [7:0]       stat_q, stat_d;
  logic [7:0]       dx_q, dx_d;
  logic [7:0]       dy_q, dy_d;
  logic [7:0]       err_q, err_d;
  logic             err_inc;
  logic             rdy, good, to;
  logic [7:0]       rx;

  assign rdy  = bus.BYTE_READY;
  assign rx   = bus.BYTE_READ;
  assign good = rdy && (bus.BYTE_ERROR_CODE == 2'b00);
  assign to   = (cnt_q == lim);

  // Only timed states count; others keep the counter at 0.
  always_comb begin
    lim = '0;
    unique case (state_q)
      S_INIT_WAIT: lim = LIM_INIT;
      S_WAIT_FF, S_ACK_FF, S_SELFTEST, S_ID,
      S_WAIT_F4, S_ACK_F4: lim = LIM_RESP;
      S_B1, S_B2: lim = LIM_PKT;
      default: lim = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    stat_d  = stat_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_inc = 1'b0;
    unique case (state_q)
      S_INIT_WAIT: begin
        if (to) begin
          state_d = S_SEND_FF;
          tx_d    = 8'hFF;
        end
      end
      S_SEND_FF: state_d = S_WAIT_FF;
      S_WAIT_FF: begin
        if (bus.BYTE_SENT) state_d = S_ACK_FF;
        else if (to)       state_d = S_INIT_WAIT;
      end
      S_ACK_FF: begin
        if (rdy)
          state_d = (good && rx == 8'hFA) ?
                    S_SELFTEST : S_INIT_WAIT;
        else if (to) state_d = S_INIT_WAIT;
      end
      S_SELFTEST: begin
        if (rdy)
          state_d = (good && rx == 8'hAA) ?
                    S_ID : S_INIT_WAIT;
        else if (to) state_d = S_INIT_WAIT;
      end
      S_ID: begin
        if (rdy) begin
          if (good && rx == 8'h00) begin
            state_d = S_SEND_F4;
            tx_d    = 8'hF4;
          end else begin
            state_d = S_INIT_WAIT;
          end
        end else if (to) begin
          state_d = S_INIT_WAIT;
        end
      end
      S_SEND_F4: state_d = S_WAIT_F4;
      S_WAIT_F4: begin
        if (bus.BYTE_SENT) state_d = S_ACK_F4;
        else if (to)       state_d = S_INIT_WAIT;
      end
      S_ACK_F4: begin
        if (rdy)
          state_d = (good && rx == 8'hFA) ?
                    S_B0 : S_INIT_WAIT;
        else if (to) state_d = S_INIT_WAIT;
      end
      // Bit 3 of the status byte is always set; use it to resync.
      S_B0: begin
        if (rdy) begin
          if (good && rx[3]) begin
            b0_d    = rx;
            state_d = S_B1;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      S_B1: begin
        if (rdy) begin
          if (good) begin
            b1_d    = rx;
            state_d = S_B2;
          end else begin
            err_inc = 1'b1;
            state_d = S_B0;
          end
        end else if (to) begin
          err_inc = 1'b1;
          state_d = S_B0;
        end
      end
      S_B2: begin
        if (rdy) begin
          if (good) begin
            stat_d  = b0_q;
            dx_d    = b1_q;
            dy_d    = rx;
            state_d = S_PUBLISH;
          end else begin
            err_inc = 1'b1;
            state_d = S_B0;
          end
        end else if (to) begin
          err_inc = 1'b1;
          state_d = S_B0;
        end
      end
      S_PUBLISH: state_d = S_B0;
      default:   state_d = S_INIT_WAIT;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (err_inc && err_q != 8'hFF)
      err_d = err_q + 8'd1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q != lim)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_INIT_WAIT;
      cnt_q   <= '0;
      tx_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      stat_q  <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      stat_q  <= stat_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
    end
  end

  assign bus.SEND_BYTE =
    (state_q == S_SEND_FF) || (state_q == S_SEND_F4);
  assign bus.BYTE_TO_SEND = tx_q;
  assign bus.READ_ENABLE =
    (state_q == S_ACK_FF)   || (state_q == S_SELFTEST) ||
    (state_q == S_ID)       || (state_q == S_ACK_F4)   ||
    (state_q == S_B0)       || (state_q == S_B1)       ||
    (state_q == S_B2)       || (state_q == S_PUBLISH);
  assign bus.INIT_DONE =
    (state_q == S_B0) || (state_q == S_B1) ||
    (state_q == S_B2) || (state_q == S_PUBLISH);
  assign bus.SEND_INTERRUPT = (state_q == S_PUBLISH);
  assign bus.MOUSE_STATUS   = stat_q;
  assign bus.MOUSE_DX       = dx_q;
  assign bus.MOUSE_DY       = dy_q;
  assign bus.PKT_ERR_CNT    = err_q;

endmodule

// File: tb/tb_mouse_master_fsm.sv
// Directed bench for mouse_master_fsm with a packet scoreboard
// checked on every SEND_INTERRUPT pulse.
module tb_mouse_master_fsm;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  mouse_master_fsm_if bus();

  mouse_master_fsm #(
    .T_INIT(20), .T_RESP(50), .T_PKT(30), .CTR_W(24)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int irqs  = 0;
  int pkts  = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.SEND_INTERRUPT === 1'b1) begin
      irqs++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL pkt_unexpected: got %0h want none",
               {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY});
      end else begin
        mon_e = exp_q.pop_front();
        assert ({bus.MOUSE_STATUS, bus.MOUSE_DX,
                 bus.MOUSE_DY} === mon_e) else begin
          fails++;
          $error("FAIL pkt_data: got %0h want %0h",
                 {bus.MOUSE_STATUS, bus.MOUSE_DX,
                  bus.MOUSE_DY}, mon_e);
        end
      end
    end
  end

  task automatic feed(input logic [7:0] b,
                      input logic [1:0] e);
    @(posedge CLK); #1;
    bus.BYTE_READ       = b;
    bus.BYTE_ERROR_CODE = e;
    bus.BYTE_READY      = 1'b1;
    @(posedge CLK); #1;
    bus.BYTE_READY      = 1'b0;
    bus.BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic wait_send(input string tag,
                           input logic [7:0] b,
                           input int exp_n,
                           input int max_n);
    int n;
    logic found;
    found = 1'b0;
    n = -1;
    for (int i = 0; i <= max_n; i++) begin
      @(negedge CLK);
      if (bus.SEND_BYTE === 1'b1) begin
        found = 1'b1;
        n = i;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
    if (found) begin
      chk({tag, "_lat"}, 32'(n), 32'(exp_n));
      chk({tag, "_byte"}, 32'(bus.BYTE_TO_SEND), 32'(b));
      @(negedge CLK);
      chk({tag, "_1cyc"}, 32'(bus.SEND_BYTE), 32'd0);
      chk({tag, "_hold"}, 32'(bus.BYTE_TO_SEND), 32'(b));
    end
  endtask

  task automatic pulse_sent();
    @(posedge CLK); #1;
    bus.BYTE_SENT = 1'b1;
    @(posedge CLK); #1;
    bus.BYTE_SENT = 1'b0;
  endtask

  task automatic finish_init(input string tag);
    feed(8'hFA, 2'b00);
    feed(8'hAA, 2'b00);
    feed(8'h00, 2'b00);
    wait_send({tag, "_f4"}, 8'hF4, 0, 5);
    chk({tag, "_pre_done"}, 32'(bus.INIT_DONE), 32'd0);
    pulse_sent();
    feed(8'hFA, 2'b00);
    @(negedge CLK);
    chk({tag, "_done"}, 32'(bus.INIT_DONE), 32'd1);
    chk({tag, "_rden"}, 32'(bus.READ_ENABLE), 32'd1);
  endtask

  task automatic send_pkt(input logic [7:0] s,
                          input logic [7:0] x,
                          input logic [7:0] y,
                          input int gap);
    exp_q.push_back({s, x, y});
    pkts++;
    feed(s, 2'b00);
    repeat (gap) @(posedge CLK);
    feed(x, 2'b00);
    feed(y, 2'b00);
    @(negedge CLK);
    chk("irq_lat", 32'(bus.SEND_INTERRUPT), 32'd1);
    @(negedge CLK);
    chk("irq_1cyc", 32'(bus.SEND_INTERRUPT), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.BYTE_SENT       = 1'b0;
    bus.BYTE_READ       = 8'h00;
    bus.BYTE_ERROR_CODE = 2'b00;
    bus.BYTE_READY      = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_send", 32'(bus.SEND_BYTE), 32'd0);
    chk("rst_tx", 32'(bus.BYTE_TO_SEND), 32'd0);
    chk("rst_rden", 32'(bus.READ_ENABLE), 32'd0);
    chk("rst_done", 32'(bus.INIT_DONE), 32'd0);
    chk("rst_irq", 32'(bus.SEND_INTERRUPT), 32'd0);
    chk("rst_mouse", 32'({bus.MOUSE_STATUS,
        bus.MOUSE_DX, bus.MOUSE_DY}), 32'd0);
    chk("rst_err", 32'(bus.PKT_ERR_CNT), 32'd0);

    @(posedge CLK); #1;
    RESET_N = 1'b1;

    // Bad ack, then silent device, then normal init.
    wait_send("ff1", 8'hFF, 20, 40);
    pulse_sent();
    chk("ackff_rden", 32'(bus.READ_ENABLE), 32'd1);
    feed(8'hFE, 2'b00);
    wait_send("ff2", 8'hFF, 20, 40);
    pulse_sent();
    wait_send("ff3", 8'hFF, 70, 100);
    chk("to_done", 32'(bus.INIT_DONE), 32'd0);
    pulse_sent();
    finish_init("init");

    send_pkt(8'h08, 8'h05, 8'hFB, 0);
    chk("err_0", 32'(bus.PKT_ERR_CNT), 32'd0);

    feed(8'h00, 2'b00);
    chk("resync_err", 32'(bus.PKT_ERR_CNT), 32'd1);
    send_pkt(8'h18, 8'h01, 8'h02, 0);

    feed(8'h28, 2'b00);
    feed(8'h11, 2'b01);
    chk("parity_err", 32'(bus.PKT_ERR_CNT), 32'd2);
    feed(8'h08, 2'b00);
    repeat (40) @(posedge CLK);
    #1;
    chk("gap_err", 32'(bus.PKT_ERR_CNT), 32'd3);
    chk("hold_mouse", 32'({bus.MOUSE_STATUS,
        bus.MOUSE_DX, bus.MOUSE_DY}), 32'h180102);

    send_pkt(8'h09, 8'h7F, 8'h80, 25);
    chk("short_gap_err", 32'(bus.PKT_ERR_CNT), 32'd3);

    // Reset while waiting for the third byte.
    feed(8'h08, 2'b00);
    feed(8'h33, 2'b00);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_mouse", 32'({bus.MOUSE_STATUS,
        bus.MOUSE_DX, bus.MOUSE_DY}), 32'd0);
    chk("mid_rst_done", 32'(bus.INIT_DONE), 32'd0);
    chk("mid_rst_rden", 32'(bus.READ_ENABLE), 32'd0);
    chk("mid_rst_err", 32'(bus.PKT_ERR_CNT), 32'd0);
    chk("mid_rst_irq", 32'(bus.SEND_INTERRUPT), 32'd0);
    chk("mid_rst_tx", 32'(bus.BYTE_TO_SEND), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    RESET_N = 1'b1;

    wait_send("ff4", 8'hFF, 20, 40);
    pulse_sent();
    finish_init("reinit");
    send_pkt(8'h08, 8'h10, 8'h20, 0);

    repeat (5) @(posedge CLK);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("irq_count", 32'(irqs), 32'(pkts));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
